instruction_fetch_serializer: RTL



---
 rtl/instruction_fetch_serializer.sv | 117 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_serializer.sv
// instruction_fetch_serializer: fetches 24-bit words at the PC and sends them MSB-first as three IR_load bytes, then waits for ReadyFlag.
// Optional ack timeout with sticky timeout_err when FETCH_TIMEOUT_EN is defined.
module instruction_fetch_serializer #(
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [23:0]       mem_rdata,
    output logic [7:0]        payload,
    output logic              IR_load,
    input  logic              ReadyFlag,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_done
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);
    typedef enum logic [2:0] {IDLE, ADDR, WAIT_MEM, SEND0, SEND1, SEND2, WAIT_ACK} state_t;
    state_t state;
    logic [23:0] sr;
    logic pend_v;
    logic [ADDR_W-1:0] pend_t, pc_nxt;
    logic ack;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    logic [CW-1:0] cnt;
`endif
    assign ack = (state == WAIT_ACK) && ReadyFlag;
    assign fetch_done = ack;
    // A redirect sampled in the ack cycle beats any older pending target.
    always_comb begin
        pc_nxt = (state == IDLE && pc_load) ? pc_target :
                 ack ? (pc_load ? pc_target : pend_v ? pend_t : pc + ADDR_W'(1)) : pc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            mem_addr <= '0;
            mem_en   <= 1'b0;
            payload  <= '0;
            IR_load  <= 1'b0;
            busy     <= 1'b0;
            sr       <= '0;
            pend_v   <= 1'b0;
            pend_t   <= '0;
`ifdef FETCH_TIMEOUT_EN
            cnt         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            pc     <= pc_nxt;
            mem_en <= 1'b0;
            if (state != IDLE && pc_load) begin
                pend_v <= 1'b1;
                pend_t <= pc_target;
            end
            case (state)
                IDLE: if (run) begin
                    state    <= ADDR;
                    mem_en   <= 1'b1;
                    mem_addr <= pc_nxt;
                    busy     <= 1'b1;
                end
                ADDR: state <= WAIT_MEM;
                WAIT_MEM: begin
                    sr      <= mem_rdata;
                    payload <= mem_rdata[23:16];
                    IR_load <= 1'b1;
                    state   <= SEND0;
                end
                SEND0: begin
                    payload <= sr[15:8];
                    state   <= SEND1;
                end
                SEND1: begin
                    payload <= sr[7:0];
                    state   <= SEND2;
                end
                SEND2: begin
                    IR_load <= 1'b0;
                    state   <= WAIT_ACK;
`ifdef FETCH_TIMEOUT_EN
                    cnt     <= '0;
`endif
                end
                WAIT_ACK: if (ReadyFlag) begin
                    pend_v   <= 1'b0;
                    state    <= run ? ADDR : IDLE;
                    mem_en   <= run;
                    mem_addr <= run ? pc_nxt : mem_addr;
                    busy     <= run;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    pend_v      <= 1'b0;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
